// File: rtl/prng_range_sampler.sv
// prng_range_sampler: reduces raw PRNG bytes to a uniform value in [0, N) by
//    power-of-two masking plus rejection, and buffers accepted values in a
//    DEPTH-entry FIFO behind a ready/valid output.
// Latency: an accepted sample reaches an empty FIFO's head one cycle after
//    its in_valid edge.
// Backpressure: a full FIFO drops accepted samples unless a pop happens the
//    same cycle. The PRNG side has no ready, so drops are counted in o_drop_cnt.
// Ports:
//    i_clock, i_reset          clock, synchronous active-high reset
//    i_in_valid, i_in_data     raw PRNG byte and its strobe
//    i_cfg_load, i_cfg_range   latch modulus N (0 means 256) and flush the FIFO
//    o_out_valid, o_out_data   FIFO head; o_out_data is always < N
//    i_out_ready               head is consumed when valid & ready
//    o_fifo_full               FIFO holds DEPTH entries
//    o_reject_cnt, o_drop_cnt  saturating rejected / dropped sample counts
//    o_health_fail             sticky repetition-test failure
// Optional feature: define PRNG_REPEAT_CHECK_EN to build the repetition
//    health tracker. Without it, o_health_fail is tied low.
module prng_range_sampler #(
   parameter int DEPTH     = 4,
   parameter int REP_LIMIT = 6
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_in_valid,
   input  logic [7:0]  i_in_data,
   input  logic        i_cfg_load,
   input  logic [7:0]  i_cfg_range,
   output logic        o_out_valid,
   output logic [7:0]  o_out_data,
   input  logic        i_out_ready,
   output logic        o_fifo_full,
   output logic [15:0] o_reject_cnt,
   output logic [15:0] o_drop_cnt,
   output logic        o_health_fail
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REP_LIMIT < 2) begin : g_bad_param
      $error("prng_range_sampler: DEPTH must be a power of two >= 2, REP_LIMIT >= 2");
   end

   logic [7:0]    r_range;
   logic [7:0]    r_mask;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [15:0]   r_reject;
   logic [15:0]   r_drop;

   logic [7:0] w_range_m1;
   logic [7:0] w_mask_next;
   logic [7:0] w_masked;
   logic       w_hf_block;
   logic       w_sample;
   logic       w_accept;
   logic       w_reject;
   logic       w_full;
   logic       w_empty;
   logic       w_pop;
   logic       w_push;
   logic       w_drop;

   // Smearing the top set bit of N-1 downward gives 2^ceil(log2 N)-1.
   // N=1 yields 0, and N=0 wraps to 8'hFF, which is the 256 case.
   assign w_range_m1  = i_cfg_range - 8'd1;
   assign w_mask_next = w_range_m1 | (w_range_m1 >> 1) | (w_range_m1 >> 2) |
                        (w_range_m1 >> 3) | (w_range_m1 >> 4) | (w_range_m1 >> 5) |
                        (w_range_m1 >> 6) | (w_range_m1 >> 7);

   assign w_masked = i_in_data & r_mask;
   // A cfg_load cycle swallows the incoming sample.
   assign w_sample = i_in_valid & ~i_cfg_load & ~w_hf_block;
   assign w_accept = w_sample & ((r_range == 8'd0) | (w_masked < r_range));
   assign w_reject = w_sample & ~w_accept;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = ~w_empty & i_out_ready & ~i_cfg_load;
   // When full, a same-cycle pop frees the slot that this push takes.
   assign w_push  = w_accept & (~w_full | w_pop);
   assign w_drop  = w_accept & w_full & ~w_pop;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_range  <= 8'd0;
         r_mask   <= 8'hFF;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
      end else if (i_cfg_load) begin
         r_range  <= i_cfg_range;
         r_mask   <= w_mask_next;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_masked;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_reject <= 16'd0;
         r_drop   <= 16'd0;
      end else begin
         if (w_reject && r_reject != 16'hFFFF) r_reject <= r_reject + 16'd1;
         if (w_drop && r_drop != 16'hFFFF)     r_drop   <= r_drop + 16'd1;
      end
   end

`ifdef PRNG_REPEAT_CHECK_EN
   localparam int RW = $clog2(REP_LIMIT + 1);

   logic [7:0]    r_last;
   logic [RW-1:0] r_run;
   logic          r_health;
   logic [RW-1:0] w_run_next;

   // The tracker sees every sampled raw byte, including ones later rejected.
   always_comb begin
      w_run_next = RW'(1);
      if (r_run != '0 && i_in_data == r_last)
         w_run_next = (r_run == RW'(REP_LIMIT)) ? r_run : r_run + RW'(1);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_last   <= 8'd0;
         r_run    <= '0;
         r_health <= 1'b0;
      end else if (w_sample) begin
         r_last <= i_in_data;
         r_run  <= w_run_next;
         if (w_run_next == RW'(REP_LIMIT)) r_health <= 1'b1;
      end
   end

   assign w_hf_block    = r_health;
   assign o_health_fail = r_health;
`else
   assign w_hf_block    = 1'b0;
   assign o_health_fail = 1'b0;
`endif

   assign o_out_valid  = ~w_empty;
   assign o_out_data   = w_empty ? 8'd0 : r_mem[r_rd_ptr];
   assign o_fifo_full  = w_full;
   assign o_reject_cnt = r_reject;
   assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_prng_range_sampler.sv
// Bench for prng_range_sampler: directed scenarios plus random traffic,
//    checked against a queue-based reference model of the sampler and FIFO.
module tb_prng_range_sampler;

   localparam int DEPTH     = 4;
   localparam int REP_LIMIT = 6;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_in_valid;
   logic [7:0]  i_in_data;
   logic        i_cfg_load;
   logic [7:0]  i_cfg_range;
   logic        o_out_valid;
   logic [7:0]  o_out_data;
   logic        i_out_ready;
   logic        o_fifo_full;
   logic [15:0] o_reject_cnt;
   logic [15:0] o_drop_cnt;
   logic        o_health_fail;

   prng_range_sampler #(.DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_in_valid   (i_in_valid),
      .i_in_data    (i_in_data),
      .i_cfg_load   (i_cfg_load),
      .i_cfg_range  (i_cfg_range),
      .o_out_valid  (o_out_valid),
      .o_out_data   (o_out_data),
      .i_out_ready  (i_out_ready),
      .o_fifo_full  (o_fifo_full),
      .o_reject_cnt (o_reject_cnt),
      .o_drop_cnt   (o_drop_cnt),
      .o_health_fail(o_health_fail)
   );

   always #5 i_clock = ~i_clock;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [7:0] mq[$];
   int         m_range;
   int         m_rej;
   int         m_drop;
   logic       m_hf;
   int         m_last;
   int         m_run;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic compare_all();
      chk("out_valid",   32'(o_out_valid),   32'(mq.size() != 0));
      chk("out_data",    32'(o_out_data),    (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("fifo_full",   32'(o_fifo_full),   32'(mq.size() == DEPTH));
      chk("reject_cnt",  32'(o_reject_cnt),  32'(m_rej));
      chk("drop_cnt",    32'(o_drop_cnt),    32'(m_drop));
      chk("health_fail", 32'(o_health_fail), 32'(m_hf));
   endtask

   task automatic do_reset(input int cycles);
      i_reset = 1'b1; i_in_valid = 1'b0; i_in_data = 8'd0;
      i_cfg_load = 1'b0; i_cfg_range = 8'd0; i_out_ready = 1'b0;
      mq.delete(); m_range = 0; m_rej = 0; m_drop = 0; m_hf = 1'b0;
      m_last = 0; m_run = 0;
      repeat (cycles) @(posedge i_clock);
      #1;
      compare_all();
      i_reset = 1'b0;
   endtask

   // One clock cycle: drive inputs, advance the model, then compare after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic ld,
                       input logic [7:0] rng, input logic rdy);
      int         lim, p;
      logic [7:0] msk;
      logic       acc, trip;
      i_in_valid = v; i_in_data = d; i_cfg_load = ld; i_cfg_range = rng; i_out_ready = rdy;
      trip = 1'b0;
      if (ld) begin
         m_range = int'(rng);
         mq.delete();
      end else begin
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (v && !m_hf) begin
`ifdef PRNG_REPEAT_CHECK_EN
            m_run  = (m_run != 0 && int'(d) == m_last) ? m_run + 1 : 1;
            m_last = int'(d);
            trip   = (m_run >= REP_LIMIT);
`endif
            lim = (m_range == 0) ? 256 : m_range;
            p = 1;
            while (p < lim) p = p * 2;
            msk = d & 8'(p - 1);
            acc = (m_range == 0) || (int'(msk) < m_range);
            if (!acc) begin
               if (m_rej < 65535) m_rej++;
            end else if (mq.size() < DEPTH) begin
               mq.push_back(msk);
            end else if (m_drop < 65535) begin
               m_drop++;
            end
         end
      end
      if (trip) m_hf = 1'b1;
      @(posedge i_clock);
      #1;
      compare_all();
   endtask

   initial begin
      logic [7:0] exp_order [4];
      logic [7:0] ranges [10];
      int         drop_before, rej_before;

      // Reset held 4 cycles: everything quiet
      do_reset(4);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("rst_fifo_full", 32'(o_fifo_full), 32'd0);
      chk("rst_out_data",  32'(o_out_data),  32'd0);

      // N=6, mask 7: 0x03 accepted, 0x0E->6 and 0xFF->7 rejected
      step(1'b0, 8'h00, 1'b1, 8'd6, 1'b0);
      step(1'b1, 8'h03, 1'b0, 8'd0, 1'b0);
      step(1'b1, 8'h0E, 1'b0, 8'd0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 8'd0, 1'b0);
      chk("n6_reject", 32'(o_reject_cnt), 32'd2);
      chk("n6_data",   32'(o_out_data),   32'd3);
      chk("n6_valid",  32'(o_out_valid),  32'd1);
      step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
      chk("n6_drained", 32'(o_out_valid), 32'd0);

      // N=0 pass-through, 5 bytes into a 4-entry FIFO with no consumer
      step(1'b0, 8'h00, 1'b1, 8'd0, 1'b0);
      exp_order[0] = 8'h10; exp_order[1] = 8'hA5; exp_order[2] = 8'h00; exp_order[3] = 8'hFE;
      for (int i = 0; i < 4; i++) step(1'b1, exp_order[i], 1'b0, 8'd0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 8'd0, 1'b0);
      chk("n0_full", 32'(o_fifo_full), 32'd1);
      chk("n0_drop", 32'(o_drop_cnt),  32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("n0_order", 32'(o_out_data), 32'(exp_order[i]));
         step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
      end
      chk("n0_empty", 32'(o_out_valid), 32'd0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 8'd0, 1'b0);
      drop_before = int'(o_drop_cnt);
      step(1'b1, 8'h99, 1'b0, 8'd0, 1'b1);
      chk("pp_full", 32'(o_fifo_full), 32'd1);
      chk("pp_drop", 32'(o_drop_cnt),  32'(drop_before));
      chk("pp_head", 32'(o_out_data),  32'h41);

      // cfg_load with 3 entries held flushes; sample on that cycle ignored
      step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
      chk("ld_held", 32'(o_out_valid), 32'd1);
      step(1'b1, 8'h55, 1'b1, 8'd1, 1'b0);
      chk("ld_flush", 32'(o_out_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 8'd0,
              1'($urandom_range(0, 1)));
         chk("n1_zero", 32'(o_out_data), 32'd0);
      end

      // Random traffic with occasional reconfiguration
      ranges[0] = 8'd0;   ranges[1] = 8'd1;   ranges[2] = 8'd2;   ranges[3] = 8'd3;
      ranges[4] = 8'd5;   ranges[5] = 8'd6;   ranges[6] = 8'd100; ranges[7] = 8'd128;
      ranges[8] = 8'd200; ranges[9] = 8'd255;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0)
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1,
                 ranges[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
         else
            step(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), 1'b0, 8'd0,
                 1'($urandom_range(0, 1)));
      end

      // Mid-stream reset discards contents
      step(1'b1, 8'h01, 1'b1, 8'd0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 8'd0, 1'b0);
      do_reset(1);
      chk("midrst_valid", 32'(o_out_valid), 32'd0);

`ifdef PRNG_REPEAT_CHECK_EN
      // Six identical bytes trip the sticky health check
      step(1'b0, 8'h00, 1'b1, 8'd200, 1'b0);
      for (int i = 0; i < REP_LIMIT; i++) begin
         chk("hf_before", 32'(o_health_fail), 32'd0);
         step(1'b1, 8'hCC, 1'b0, 8'd0, 1'b1);
      end
      chk("hf_set", 32'(o_health_fail), 32'd1);
      rej_before  = int'(o_reject_cnt);
      drop_before = int'(o_drop_cnt);
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hF0 + i), 1'b0, 8'd0, 1'b1);
      chk("hf_sticky", 32'(o_health_fail), 32'd1);
      chk("hf_no_rej", 32'(o_reject_cnt),  32'(rej_before));
      chk("hf_no_drop", 32'(o_drop_cnt),   32'(drop_before));
      chk("hf_no_push", 32'(o_out_valid),  32'd0);
      do_reset(1);
      chk("hf_cleared", 32'(o_health_fail), 32'd0);
`else
      for (int i = 0; i < 8; i++) step(1'b1, 8'hCC, 1'b0, 8'd0, 1'b1);
      chk("hf_tied", 32'(o_health_fail), 32'd0);
      rej_before  = 0;
      drop_before = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
